pc_stack_control: RTL and testbench
===================================

Name: pc_stack_control

Overview:
Sequential control stage directly downstream of the instruction decoder. Consumes the decoder's 4-bit action code (branch_stack_C_Z_detec), branch target (PC_branch) and push data (A_TO_STACK). Owns the 12-bit program counter, the hardware LIFO shared by data pushes and return addresses, the interrupt-enable flag and the halt state. Returns popped data to the decoder on STACK_TO_A.

Parameters:
STACK_DEPTH, 16, number of 16-bit stack entries (power of 2, >=2)
RESET_PC, 12'h000, PC value after reset
IRQ_VECTOR, 12'hFF0, interrupt entry address (used only with PC_IRQ_EN)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  action code valid this cycle; when 0 all state holds
branch_stack_C_Z_detec  in  4  decoder action code
PC_branch  in  12  jump/call target
A_TO_STACK  in  16  data for PUSHA
irq  in  1  level interrupt request (ignored without PC_IRQ_EN)
PC  out  12  program counter
STACK_TO_A  out  16  last popped data word
halted  out  1  core halted
ien  out  1  interrupt enable flag
stack_full  out  1  sp_level==STACK_DEPTH
stack_empty  out  1  sp_level==0
stack_err  out  1  sticky overflow/underflow flag
sp_level  out  clog2(STACK_DEPTH)+1  current occupancy
irq_ack  out  1  one-cycle pulse on interrupt entry

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-operation): PC=RESET_PC, STACK_TO_A=0, halted=0, ien=0, sp_level=0, stack_err=0, irq_ack=0; stack contents don't-care.
- Action executes on the rising edge where instr_valid=1 and halted=0. Results are visible the following cycle; latency 1 for every code.
- PC arithmetic is modulo 4096: 12'hFFF+1 -> 12'h000, 12'hFFF+2 -> 12'h001.
- 4'b1111 (inc): PC<=PC+1.
- 4'b0000 JMP: PC<=PC_branch.
- 4'b0001 JSR: push {4'h0,PC+1}; PC<=PC_branch. If full: no push, stack_err<=1, PC<=PC+1.
- 4'b0010 PUSHA: push A_TO_STACK; PC<=PC+1. If full: no push, stack_err<=1.
- 4'b0011 POPA: STACK_TO_A<=top; sp_level-1; PC<=PC+1. If empty: STACK_TO_A holds, stack_err<=1.
- 4'b0100 RET: PC<=top[11:0]; sp_level-1. If empty: stack_err<=1, PC<=PC+1.
- 4'b0101 / 4'b0110 (skip taken on C / Z): PC<=PC+2.
- 4'b0111 ION: ien<=1, PC+1. 4'b1000 IOF: ien<=0, PC+1.
- 4'b1001 HALT: halted<=1, PC holds. Leaves halt only via reset (or interrupt, see below).
- Codes 1010-1110: treated as inc (PC+1), no other effect.
- Stack: array plus pointer. Push writes entry[sp_level] and increments. Pop reads entry[sp_level-1] and decrements. The full/empty guards above mean sp_level never wraps.
- stack_err stays set until reset.
- instr_valid=0: no state change; irq_ack=0.

Optional Feature:
PC_IRQ_EN
- Defined:
  - Interrupt is taken at an edge where irq=1, ien=1, not full, and either (instr_valid=1) or halted=1.
  - Entry: push {4'h0,PC} (the pending instruction is not executed), PC<=IRQ_VECTOR, ien<=0, halted<=0, irq_ack<=1 for one cycle.
  - Priority: the interrupt beats the current action code.
  - If the stack is full: interrupt is not taken, stack_err<=1, and the instruction executes normally.
- Undefined: irq is ignored, irq_ack is tied 0, and ION/IOF only write ien.

Test Plan:
- Reset then 5 valid cycles of 4'b1111 -> PC=0x005. Hold instr_valid=0 for 3 cycles -> PC stays 0x005.
- PC=0xFFE, code 0101 -> PC=0x000. From 0xFFF, code 1111 -> 0x000.
- At PC=0x010, JSR with PC_branch=0x200 -> PC=0x200, sp_level=1. Then RET -> PC=0x011, sp_level=0, stack_err=0.
- PUSHA 0xABCD, PUSHA 0x1234, POPA, POPA -> STACK_TO_A=0x1234 then 0xABCD. Third POPA -> stack_err=1, STACK_TO_A stays 0xABCD.
- STACK_DEPTH+1 PUSHA -> stack_full=1 after DEPTH pushes, final push sets stack_err and leaves sp_level=DEPTH. HALT -> PC frozen, halted=1, later codes ignored until rst.
- (PC_IRQ_EN) ION at PC=0x020, then irq=1 with next instruction at PC=0x021 -> PC=0xFF0, irq_ack pulse, ien=0, top=0x0021. RET -> PC=0x021. Halted with ien=1 plus irq -> halted=0, PC=0xFF0.

Source files
------------

// File: rtl/pc_stack_control.sv
// pc_stack_control: owns the 12-bit program counter, the LIFO shared by data
// pushes and return addresses, the interrupt-enable flag and the halt state.
// Executes one decoder action code per valid cycle with single-cycle latency.
// Optional feature: define PC_IRQ_EN to enable level-sensitive interrupt
// entry (push current PC, jump to IRQ_VECTOR, one-cycle irq_ack pulse).
module pc_stack_control #(
   parameter int          STACK_DEPTH = 16,
   parameter logic [11:0] RESET_PC    = 12'h000,
   parameter logic [11:0] IRQ_VECTOR  = 12'hFF0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          instr_valid,
   input  logic [3:0]                    branch_stack_C_Z_detec,
   input  logic [11:0]                   PC_branch,
   input  logic [15:0]                   A_TO_STACK,
   input  logic                          irq,
   output logic [11:0]                   PC,
   output logic [15:0]                   STACK_TO_A,
   output logic                          halted,
   output logic                          ien,
   output logic                          stack_full,
   output logic                          stack_empty,
   output logic                          stack_err,
   output logic [$clog2(STACK_DEPTH):0]  sp_level,
   output logic                          irq_ack
);
   localparam int             SPW     = $clog2(STACK_DEPTH) + 1;
   localparam int             IW      = SPW - 1;
   localparam logic [SPW-1:0] DEPTH_L = SPW'(STACK_DEPTH);

   localparam logic [3:0] OP_JMP   = 4'b0000;
   localparam logic [3:0] OP_JSR   = 4'b0001;
   localparam logic [3:0] OP_PUSHA = 4'b0010;
   localparam logic [3:0] OP_POPA  = 4'b0011;
   localparam logic [3:0] OP_RET   = 4'b0100;
   localparam logic [3:0] OP_SKC   = 4'b0101;
   localparam logic [3:0] OP_SKZ   = 4'b0110;
   localparam logic [3:0] OP_ION   = 4'b0111;
   localparam logic [3:0] OP_IOF   = 4'b1000;
   localparam logic [3:0] OP_HALT  = 4'b1001;

   logic [11:0]     pc_q, pc_d;
   logic [15:0]     a_q, a_d;
   logic            halt_q, halt_d;
   logic            ien_q, ien_d;
   logic            err_q, err_d;
   logic            ack_q, ack_d;
   logic [SPW-1:0]  sp_q, sp_d;
   logic [15:0]     stack_q [STACK_DEPTH];

   logic            push_en;
   logic [15:0]     push_data;
   logic            irq_take;
   logic            full, empty;
   logic [SPW-1:0]  sp_m1;
   logic [15:0]     top;
   logic [11:0]     pc_inc, pc_inc2;

   assign full    = (sp_q == DEPTH_L);
   assign empty   = (sp_q == '0);
   assign sp_m1   = sp_q - 1'b1;
   // Only read when not empty, so sp_m1 is a valid entry index there.
   assign top     = stack_q[sp_m1[IW-1:0]];
   assign pc_inc  = pc_q + 12'd1;
   assign pc_inc2 = pc_q + 12'd2;

`ifndef PC_IRQ_EN
   // Interrupt inputs have no function without the interrupt feature.
   logic unused_irq;
   assign unused_irq = ^{irq, IRQ_VECTOR};
`endif

   // Next-state decode: interrupt entry first, then the decoder action code.
   always_comb begin
      pc_d      = pc_q;
      a_d       = a_q;
      halt_d    = halt_q;
      ien_d     = ien_q;
      err_d     = err_q;
      ack_d     = 1'b0;
      sp_d      = sp_q;
      push_en   = 1'b0;
      push_data = '0;
      irq_take  = 1'b0;
`ifdef PC_IRQ_EN
      // A halted core wakes on interrupt even without a valid instruction.
      if (irq && ien_q && (instr_valid || halt_q)) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            irq_take  = 1'b1;
            push_en   = 1'b1;
            push_data = {4'h0, pc_q};
            sp_d      = sp_q + 1'b1;
            pc_d      = IRQ_VECTOR;
            ien_d     = 1'b0;
            halt_d    = 1'b0;
            ack_d     = 1'b1;
         end
      end
`endif
      if (!irq_take && instr_valid && !halt_q) begin
         case (branch_stack_C_Z_detec)
            OP_JMP: pc_d = PC_branch;
            OP_JSR: begin
               if (full) begin
                  err_d = 1'b1;
                  pc_d  = pc_inc;
               end else begin
                  push_en   = 1'b1;
                  push_data = {4'h0, pc_inc};
                  sp_d      = sp_q + 1'b1;
                  pc_d      = PC_branch;
               end
            end
            OP_PUSHA: begin
               pc_d = pc_inc;
               if (full) begin
                  err_d = 1'b1;
               end else begin
                  push_en   = 1'b1;
                  push_data = A_TO_STACK;
                  sp_d      = sp_q + 1'b1;
               end
            end
            OP_POPA: begin
               pc_d = pc_inc;
               if (empty) begin
                  err_d = 1'b1;
               end else begin
                  a_d  = top;
                  sp_d = sp_m1;
               end
            end
            OP_RET: begin
               if (empty) begin
                  err_d = 1'b1;
                  pc_d  = pc_inc;
               end else begin
                  pc_d = top[11:0];
                  sp_d = sp_m1;
               end
            end
            OP_SKC, OP_SKZ: pc_d = pc_inc2;
            OP_ION: begin
               ien_d = 1'b1;
               pc_d  = pc_inc;
            end
            OP_IOF: begin
               ien_d = 1'b0;
               pc_d  = pc_inc;
            end
            OP_HALT: halt_d = 1'b1;
            default: pc_d = pc_inc;
         endcase
      end
   end

   // Control state registers; synchronous reset wins over any action.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         a_q    <= '0;
         halt_q <= 1'b0;
         ien_q  <= 1'b0;
         err_q  <= 1'b0;
         ack_q  <= 1'b0;
         sp_q   <= '0;
      end else begin
         pc_q   <= pc_d;
         a_q    <= a_d;
         halt_q <= halt_d;
         ien_q  <= ien_d;
         err_q  <= err_d;
         ack_q  <= ack_d;
         sp_q   <= sp_d;
      end
   end

   // Stack storage: contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (!rst && push_en) stack_q[sp_q[IW-1:0]] <= push_data;
   end

   assign PC          = pc_q;
   assign STACK_TO_A  = a_q;
   assign halted      = halt_q;
   assign ien         = ien_q;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign stack_err   = err_q;
   assign sp_level    = sp_q;
   assign irq_ack     = ack_q;

endmodule

// File: tb/tb_pc_stack_control.sv
// Bench for pc_stack_control: directed vector table, hand sequences for the
// stack-fill / halt / interrupt corners, then randomized traffic against a
// queue-based reference model.
module tb_pc_stack_control;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst, instr_valid, irq;
   logic [3:0]  code;
   logic [11:0] br;
   logic [15:0] a_in;
   logic [11:0] PC;
   logic [15:0] STACK_TO_A;
   logic        halted, ien, stack_full, stack_empty, stack_err, irq_ack;
   logic [4:0]  sp_level;

   pc_stack_control #(.STACK_DEPTH(DEPTH), .RESET_PC(12'h000), .IRQ_VECTOR(12'hFF0)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid),
      .branch_stack_C_Z_detec(code), .PC_branch(br), .A_TO_STACK(a_in), .irq(irq),
      .PC(PC), .STACK_TO_A(STACK_TO_A), .halted(halted), .ien(ien),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err),
      .sp_level(sp_level), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference model state
   int          m_pc;
   logic [15:0] m_q[$];
   logic [15:0] m_a;
   bit          m_halt, m_ien, m_err, m_ack;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void model_step(bit r, bit v, logic [3:0] c, logic [11:0] b,
                                      logic [15:0] d, bit ir);
      if (r) begin
         m_pc = 0; m_q.delete(); m_a = 0; m_halt = 0; m_ien = 0; m_err = 0; m_ack = 0;
         return;
      end
      m_ack = 0;
`ifdef PC_IRQ_EN
      if (ir && m_ien && (v || m_halt)) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back(16'(m_pc));
            m_pc = 'hFF0; m_ien = 0; m_halt = 0; m_ack = 1;
            return;
         end
         m_err = 1;
      end
`else
      // irq has no effect without the interrupt feature
      m_ack = ir & 1'b0;
`endif
      if (!v || m_halt) return;
      case (c)
         4'd0: m_pc = int'(b);
         4'd1: if (m_q.size() == DEPTH) begin
                  m_err = 1; m_pc = (m_pc + 1) % 4096;
               end else begin
                  m_q.push_back(16'((m_pc + 1) % 4096)); m_pc = int'(b);
               end
         4'd2: begin
                  if (m_q.size() == DEPTH) m_err = 1; else m_q.push_back(d);
                  m_pc = (m_pc + 1) % 4096;
               end
         4'd3: begin
                  if (m_q.size() == 0) m_err = 1; else m_a = m_q.pop_back();
                  m_pc = (m_pc + 1) % 4096;
               end
         4'd4: if (m_q.size() == 0) begin
                  m_err = 1; m_pc = (m_pc + 1) % 4096;
               end else begin
                  m_pc = int'(m_q.pop_back() & 16'h0FFF);
               end
         4'd5, 4'd6: m_pc = (m_pc + 2) % 4096;
         4'd7: begin m_ien = 1; m_pc = (m_pc + 1) % 4096; end
         4'd8: begin m_ien = 0; m_pc = (m_pc + 1) % 4096; end
         4'd9: m_halt = 1;
         default: m_pc = (m_pc + 1) % 4096;
      endcase
   endfunction

   // one clock: drive, edge, advance model, settle for sampling
   task automatic cyc(bit r, bit v, logic [3:0] c, logic [11:0] b, logic [15:0] d, bit ir);
      rst = r; instr_valid = v; code = c; br = b; a_in = d; irq = ir;
      @(posedge clk);
      model_step(r, v, c, b, d, ir);
      #1;
   endtask

   task automatic chk_state(string nm, logic [11:0] pc, int sp, logic [15:0] a, bit err, bit hlt);
      check({nm, "_pc"}, 64'(PC), 64'(pc));
      check({nm, "_sp"}, 64'(sp_level), 64'(sp));
      check({nm, "_a"}, 64'(STACK_TO_A), 64'(a));
      check({nm, "_err"}, 64'(stack_err), 64'(err));
      check({nm, "_halt"}, 64'(halted), 64'(hlt));
      check({nm, "_full"}, 64'(stack_full), 64'(sp == DEPTH));
      check({nm, "_empty"}, 64'(stack_empty), 64'(sp == 0));
   endtask

   typedef struct {
      bit          r;
      bit          v;
      logic [3:0]  c;
      logic [11:0] b;
      logic [15:0] d;
      logic [11:0] pc;
      int          sp;
      logic [15:0] a;
      bit          err;
      bit          hlt;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(bit r, bit v, logic [3:0] c, logic [11:0] b, logic [15:0] d,
                               logic [11:0] pc, int sp, logic [15:0] a, bit err, bit hlt);
      vec_t t;
      t.r = r; t.v = v; t.c = c; t.b = b; t.d = d;
      t.pc = pc; t.sp = sp; t.a = a; t.err = err; t.hlt = hlt;
      tbl.push_back(t);
   endfunction

   initial begin
      rst = 1'b1; instr_valid = 1'b0; code = 4'h0; br = '0; a_in = '0; irq = 1'b0;

      //  r  v  code   br      data      PC      sp a        err halt
      add(1, 0, 4'hF, 12'h000, 16'h0000, 12'h000, 0, 16'h0000, 0, 0);
      for (int i = 1; i <= 5; i++)
         add(0, 1, 4'hF, 12'h000, 16'h0000, 12'(i), 0, 16'h0000, 0, 0);
      for (int i = 0; i < 3; i++)
         add(0, 0, 4'h0, 12'hABC, 16'h0000, 12'h005, 0, 16'h0000, 0, 0);
      add(0, 1, 4'h0, 12'hFFE, 16'h0000, 12'hFFE, 0, 16'h0000, 0, 0);
      add(0, 1, 4'h5, 12'h000, 16'h0000, 12'h000, 0, 16'h0000, 0, 0);
      add(0, 1, 4'h0, 12'hFFF, 16'h0000, 12'hFFF, 0, 16'h0000, 0, 0);
      add(0, 1, 4'hF, 12'h000, 16'h0000, 12'h000, 0, 16'h0000, 0, 0);
      add(0, 1, 4'h0, 12'h010, 16'h0000, 12'h010, 0, 16'h0000, 0, 0);
      add(0, 1, 4'h1, 12'h200, 16'h0000, 12'h200, 1, 16'h0000, 0, 0);
      add(0, 1, 4'h4, 12'h000, 16'h0000, 12'h011, 0, 16'h0000, 0, 0);
      add(0, 1, 4'h2, 12'h000, 16'hABCD, 12'h012, 1, 16'h0000, 0, 0);
      add(0, 1, 4'h2, 12'h000, 16'h1234, 12'h013, 2, 16'h0000, 0, 0);
      add(0, 1, 4'h3, 12'h000, 16'h0000, 12'h014, 1, 16'h1234, 0, 0);
      add(0, 1, 4'h3, 12'h000, 16'h0000, 12'h015, 0, 16'hABCD, 0, 0);
      add(0, 1, 4'h3, 12'h000, 16'h0000, 12'h016, 0, 16'hABCD, 1, 0);
      add(1, 1, 4'h0, 12'h777, 16'h0000, 12'h000, 0, 16'h0000, 0, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].d, 1'b0);
         chk_state($sformatf("vec%0d", i), tbl[i].pc, tbl[i].sp, tbl[i].a, tbl[i].err, tbl[i].hlt);
      end

      // fill the stack past its depth, then halt and confirm it sticks
      for (int k = 1; k <= DEPTH + 1; k++) begin
         cyc(0, 1, 4'h2, 12'h000, 16'(16'h1000 + k), 1'b0);
         chk_state($sformatf("fill%0d", k), 12'(k), (k > DEPTH) ? DEPTH : k, 16'h0000,
                   k > DEPTH, 1'b0);
      end
      cyc(0, 1, 4'h9, 12'h000, 16'h0000, 1'b0);
      chk_state("halt", 12'h011, DEPTH, 16'h0000, 1'b1, 1'b1);
      cyc(0, 1, 4'h0, 12'h300, 16'h0000, 1'b0);
      chk_state("halt_jmp", 12'h011, DEPTH, 16'h0000, 1'b1, 1'b1);
      cyc(0, 1, 4'h3, 12'h000, 16'h0000, 1'b0);
      chk_state("halt_pop", 12'h011, DEPTH, 16'h0000, 1'b1, 1'b1);
      cyc(1, 0, 4'h0, 12'h000, 16'h0000, 1'b0);
      chk_state("halt_rst", 12'h000, 0, 16'h0000, 1'b0, 1'b0);

      // RET on empty stack falls through and flags the error
      cyc(0, 1, 4'h4, 12'h000, 16'h0000, 1'b0);
      chk_state("ret_empty", 12'h001, 0, 16'h0000, 1'b1, 1'b0);
      cyc(1, 0, 4'h0, 12'h000, 16'h0000, 1'b0);

      // skip on Z, reserved codes, interrupt-enable flag
      cyc(0, 1, 4'h6, 12'h000, 16'h0000, 1'b0);
      check("skz_pc", 64'(PC), 64'h002);
      for (int c = 10; c <= 14; c++) cyc(0, 1, 4'(c), 12'h555, 16'h0000, 1'b0);
      chk_state("resv", 12'h007, 0, 16'h0000, 1'b0, 1'b0);
      cyc(0, 1, 4'h7, 12'h000, 16'h0000, 1'b0);
      check("ion_ien", 64'(ien), 64'h1);
      check("ion_pc", 64'(PC), 64'h008);
      cyc(0, 1, 4'h8, 12'h000, 16'h0000, 1'b0);
      check("iof_ien", 64'(ien), 64'h0);
      check("iof_pc", 64'(PC), 64'h009);
      check("noirq_ack", 64'(irq_ack), 64'h0);

`ifdef PC_IRQ_EN
      cyc(1, 0, 4'h0, 12'h000, 16'h0000, 1'b0);
      cyc(0, 1, 4'h0, 12'h020, 16'h0000, 1'b0);
      cyc(0, 1, 4'h7, 12'h000, 16'h0000, 1'b0);
      check("irq_pre_pc", 64'(PC), 64'h021);
      cyc(0, 1, 4'hF, 12'h000, 16'h0000, 1'b1);
      check("irq_pc", 64'(PC), 64'hFF0);
      check("irq_ack", 64'(irq_ack), 64'h1);
      check("irq_ien", 64'(ien), 64'h0);
      check("irq_sp", 64'(sp_level), 64'h1);
      cyc(0, 1, 4'hF, 12'h000, 16'h0000, 1'b0);
      check("irq_ack_pulse", 64'(irq_ack), 64'h0);
      check("irq_next_pc", 64'(PC), 64'hFF1);
      cyc(0, 1, 4'h4, 12'h000, 16'h0000, 1'b0);
      check("irq_ret_pc", 64'(PC), 64'h021);
      check("irq_ret_sp", 64'(sp_level), 64'h0);
      cyc(0, 1, 4'h7, 12'h000, 16'h0000, 1'b0);
      cyc(0, 1, 4'h9, 12'h000, 16'h0000, 1'b0);
      check("irq_halted", 64'(halted), 64'h1);
      cyc(0, 0, 4'hF, 12'h000, 16'h0000, 1'b1);
      check("irq_wake_halt", 64'(halted), 64'h0);
      check("irq_wake_pc", 64'(PC), 64'hFF0);
      check("irq_wake_ack", 64'(irq_ack), 64'h1);
`endif

      // randomized traffic against the reference model
      cyc(1, 0, 4'h0, 12'h000, 16'h0000, 1'b0);
      for (int n = 0; n < 1500; n++) begin
         bit          r, v, ir;
         logic [3:0]  c;
         r  = ($urandom_range(0, 39) == 0);
         v  = ($urandom_range(0, 3) != 0);
         ir = ($urandom_range(0, 7) == 0);
         c  = 4'($urandom_range(0, 15));
         if (c == 4'h9 && $urandom_range(0, 1) == 0) c = 4'hF;
         cyc(r, v, c, 12'($urandom), 16'($urandom), ir);
         check($sformatf("rand%0d", n),
               {25'd0, PC, sp_level, STACK_TO_A, stack_err, halted, ien, irq_ack,
                stack_full, stack_empty},
               {25'd0, 12'(m_pc), 5'(m_q.size()), m_a, m_err, m_halt, m_ien, m_ack,
                m_q.size() == DEPTH, m_q.size() == 0});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
